seq_pipe_add3_arb: RTL and testbench
====================================

# seq_pipe_add3_arb

Shares one two-stage pipelined 3-input 8-bit adder between two requesters. A round-robin arbiter selects one operand triple per cycle, and a tag travels down the pipeline so each sum returns on the response port of the requester that issued it. A single global-enable stall handles response backpressure. The block sits between two independent producers and the add3 datapath. It is the sequencing and sharing layer for that datapath.

## Interface
Parameters:
- nbits, 8, operand and result width

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- req0_val  input  1  requester 0 operand triple valid
- req0_rdy  output  1  requester 0 triple accepted this cycle
- req0_in0, req0_in1, req0_in2  input  nbits  requester 0 operands
- req1_val  input  1  requester 1 operand triple valid
- req1_rdy  output  1  requester 1 triple accepted this cycle
- req1_in0, req1_in1, req1_in2  input  nbits  requester 1 operands
- resp0_val  output  1  sum for requester 0 valid
- resp0_rdy  input  1  requester 0 consumes sum
- resp1_val  output  1  sum for requester 1 valid
- resp1_rdy  input  1  requester 1 consumes sum
- resp_out  output  nbits  stage-2 sum, shared by both response ports
- out01  output  nbits  stage-1 registered partial sum in0+in1 (debug)
- busy  output  1  either pipeline stage holds a valid entry

## Operation
- Stage 1 registers: s1_val, s1_tag, s1_sum01 = in0+in1 (mod 2^nbits), s1_in2.
- Stage 2 registers: s2_val, s2_tag, s2_sum = s1_sum01 + s1_in2 (mod 2^nbits).
- Arithmetic is unsigned modulo 2^nbits. Carries are discarded, and negative operands are handled as two's complement wrap.
- Priority register prio (0 or 1), reset to 0.
- Grant (combinational):
  - Both req valid: grant = prio.
  - Otherwise: grant = the single valid requester.
  - Neither valid: no grant.
- Stall:
  - stall = s2_val & !(s2_tag ? resp1_rdy : resp0_rdy).
  - en = !stall.
- reqK_rdy = en & (grant == K) & reqK_val. A request is accepted when its val and rdy are both high.
- On each rising edge with en = 1:
  - s2 loads s1 (val, tag, sum).
  - s1 loads the granted triple with s1_val = 1 if a request is accepted, otherwise s1_val = 0 (bubble).
- On each rising edge with en = 0, s1 and s2 hold.
- prio updates on acceptance only: prio <= ~granted_id. No acceptance leaves prio unchanged.
- Response outputs:
  - resp0_val = s2_val & (s2_tag == 0).
  - resp1_val = s2_val & (s2_tag == 1).
  - resp_out = s2_sum.
- busy = s1_val | s2_val.
- out01 = s1_sum01.
- Bubbles are not collapsed: a stall freezes both stages even if s1 is empty.
- Requester val may drop without acceptance. Requesters must hold operands stable while val is high and rdy is low.

## Timing
- Reset (reset_n low, asynchronous, immediate): s1_val = s2_val = 0, all data and tag registers 0, prio = 0. The block then drives resp0_val = resp1_val = 0, resp_out = 0, out01 = 0, busy = 0, and req0_rdy = req1_rdy = 0 while reset_n is low.
- Reset mid-operation discards all in-flight entries. No response is produced for them.
- Latency:
  - A request accepted at edge t makes its resp val high after edge t+1 (two edges: t loads s1, t+1 loads s2), when no stall occurs.
  - The response remains valid until the edge where its rdy is high.
- Throughput: one acceptance per cycle when unstalled.
- Simultaneous response consumed and new request: both occur in the same cycle.
- Backpressure propagation: a stall lowers both req rdy in the same cycle (combinational).

## Test plan
- Single requester:
  - Stimulus: req0 sends (1,2,4) at cycle 0, resp0_rdy=1.
  - Response: out01=3 after the first edge. After the second edge, resp0_val=1, resp_out=7, resp1_val=0.
- Round-robin:
  - Stimulus: both requesters valid continuously; req0 sends (1,1,1), req1 sends (2,2,2), both resp rdy=1.
  - Response: grants alternate 0,1,0,1 starting with 0. resp_out alternates 3,6 on resp0_val and resp1_val.
- Overflow wrap:
  - Stimulus: req1 sends (127,1,0), then (64,64,64), then (-1,0,-128).
  - Response: resp_out = 8'h80, then 8'hC0, then 8'h7F.
- Backpressure stall:
  - Stimulus: resp0_rdy=0 while resp0_val=1; req1 is valid.
  - Response: req1_rdy=0, resp_out, out01 and stage contents hold. Raising resp0_rdy drains in order with no loss or duplication.
- Asynchronous reset mid-flight:
  - Stimulus: two entries in flight; pulse reset_n low between clock edges.
  - Response: busy, resp*_val and out01 go to 0 immediately. No stale responses appear afterward. After release, the first grant goes to req0 when both requesters are valid.
- Random:
  - Stimulus: 200 cycles of random vals, operands and resp rdy.
  - Response: the per-requester response sequence matches a reference model, with sums mod 256, in order, with no drops.

Source files
------------

// File: rtl/seq_pipe_add3_arb.sv
// seq_pipe_add3_arb: two requesters share one two-stage pipelined 3-input adder.
// A round-robin arbiter picks one operand triple per cycle. A tag rides with
// each entry so the sum comes back on the port of the requester that issued it.
// A response that is not consumed stalls the whole pipeline.
//
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   reqK_val/reqK_rdy              requester K handshake (rdy is combinational)
//   reqK_in0/in1/in2               requester K operands
//   respK_val/respK_rdy            response K handshake
//   resp_out                       stage-2 sum, shared by both response ports
//   out01                          stage-1 partial sum in0+in1 (debug)
//   busy                           either pipeline stage holds a valid entry
module seq_pipe_add3_arb #(
    parameter int unsigned nbits = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_val,
    output logic             req0_rdy,
    input  logic [nbits-1:0] req0_in0,
    input  logic [nbits-1:0] req0_in1,
    input  logic [nbits-1:0] req0_in2,
    input  logic             req1_val,
    output logic             req1_rdy,
    input  logic [nbits-1:0] req1_in0,
    input  logic [nbits-1:0] req1_in1,
    input  logic [nbits-1:0] req1_in2,
    output logic             resp0_val,
    input  logic             resp0_rdy,
    output logic             resp1_val,
    input  logic             resp1_rdy,
    output logic [nbits-1:0] resp_out,
    output logic [nbits-1:0] out01,
    output logic             busy
);

    // Pipeline and arbitration state
    logic             s1_val;
    logic             s1_tag;
    logic [nbits-1:0] s1_sum01;
    logic [nbits-1:0] s1_in2;
    logic             s2_val;
    logic             s2_tag;
    logic [nbits-1:0] s2_sum;
    logic             prio;

    logic             stall_c;
    logic             en_c;
    logic             grant_c;
    logic             accept_c;
    logic [nbits-1:0] g_in0_c;
    logic [nbits-1:0] g_in1_c;
    logic [nbits-1:0] g_in2_c;

    // Stall, grant and operand selection
    always_comb begin
        stall_c  = s2_val & ~(s2_tag ? resp1_rdy : resp0_rdy);
        en_c     = ~stall_c;
        // With both valid the priority bit decides; otherwise the lone valid one wins.
        grant_c  = (req0_val & req1_val) ? prio : req1_val;
        accept_c = en_c & (req0_val | req1_val);
        g_in0_c  = grant_c ? req1_in0 : req0_in0;
        g_in1_c  = grant_c ? req1_in1 : req0_in1;
        g_in2_c  = grant_c ? req1_in2 : req0_in2;
    end

    // reset_n gating keeps both rdy low while reset is held
    assign req0_rdy = reset_n & en_c & ~grant_c & req0_val;
    assign req1_rdy = reset_n & en_c &  grant_c & req1_val;

    // Pipeline registers; a stall freezes both stages, bubbles included
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_val   <= 1'b0;
            s1_tag   <= 1'b0;
            s1_sum01 <= '0;
            s1_in2   <= '0;
            s2_val   <= 1'b0;
            s2_tag   <= 1'b0;
            s2_sum   <= '0;
            prio     <= 1'b0;
        end else if (en_c) begin
            s2_val <= s1_val;
            s2_tag <= s1_tag;
            s2_sum <= s1_sum01 + s1_in2;
            s1_val <= accept_c;
            if (accept_c) begin
                s1_tag   <= grant_c;
                s1_sum01 <= g_in0_c + g_in1_c;
                s1_in2   <= g_in2_c;
                prio     <= ~grant_c;
            end
        end
    end

    assign resp0_val = s2_val & ~s2_tag;
    assign resp1_val = s2_val &  s2_tag;
    assign resp_out  = s2_sum;
    assign out01     = s1_sum01;
    assign busy      = s1_val | s2_val;

endmodule

// File: tb/tb_seq_pipe_add3_arb.sv
module tb_seq_pipe_add3_arb;

    logic       clk;
    logic       reset_n;
    logic       req0_val, req0_rdy, req1_val, req1_rdy;
    logic [7:0] req0_in0, req0_in1, req0_in2;
    logic [7:0] req1_in0, req1_in1, req1_in2;
    logic       resp0_val, resp0_rdy, resp1_val, resp1_rdy;
    logic [7:0] resp_out, out01;
    logic       busy;

    seq_pipe_add3_arb #(.nbits(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_val(req0_val), .req0_rdy(req0_rdy),
        .req0_in0(req0_in0), .req0_in1(req0_in1), .req0_in2(req0_in2),
        .req1_val(req1_val), .req1_rdy(req1_rdy),
        .req1_in0(req1_in0), .req1_in1(req1_in1), .req1_in2(req1_in2),
        .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .resp_out(resp_out), .out01(out01), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic acc0, acc1;

    typedef struct {
        logic       id;
        logic [7:0] a, b, c;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with inputs applied: record handshakes, then advance one edge.
    task automatic cycle();
        logic [7:0] e;
        #1;
        acc0 = req0_val && req0_rdy;
        acc1 = req1_val && req1_rdy;
        if (acc0) q0.push_back(8'(req0_in0 + req0_in1 + req0_in2));
        if (acc1) q1.push_back(8'(req1_in0 + req1_in1 + req1_in2));
        if (resp0_val && resp0_rdy) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL resp0_unexpected: got %0h expected none", resp_out);
            end else begin
                e = q0.pop_front();
                chk("resp0_sb", resp_out, e);
            end
        end
        if (resp1_val && resp1_rdy) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL resp1_unexpected: got %0h expected none", resp_out);
            end else begin
                e = q1.pop_front();
                chk("resp1_sb", resp_out, e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set0(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req0_val = v; req0_in0 = a; req0_in1 = b; req0_in2 = c;
    endtask

    task automatic set1(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req1_val = v; req1_in0 = a; req1_in1 = b; req1_in2 = c;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        vecs[0] = '{1'b0,  8'd10,  8'd20,  8'd30, 8'h3C};
        vecs[1] = '{1'b1, 8'd127,   8'd1,   8'd0, 8'h80};
        vecs[2] = '{1'b1,  8'd64,  8'd64,  8'd64, 8'hC0};
        vecs[3] = '{1'b1, 8'hFF,   8'd0,  8'h80, 8'h7F};
        vecs[4] = '{1'b0, 8'd200, 8'd100,   8'd0, 8'h2C};
        vecs[5] = '{1'b0, 8'hFF,  8'hFF,  8'hFF, 8'hFD};

        // Reset values, with both requesters valid to show rdy is held low
        reset_n = 1'b0;
        set0(1'b1, 8'd1, 8'd1, 8'd1);
        set1(1'b1, 8'd2, 8'd2, 8'd2);
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_resp0_val", resp0_val, 0);
        chk("rst_resp1_val", resp1_val, 0);
        chk("rst_resp_out", resp_out, 0);
        chk("rst_out01", out01, 0);
        chk("rst_req0_rdy", req0_rdy, 0);
        chk("rst_req1_rdy", req1_rdy, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Round-robin: both valid, grants alternate starting with req0; sums 3 and 6
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_req0_rdy", req0_rdy, (i % 2 == 0) ? 1 : 0);
            chk("rr_req1_rdy", req1_rdy, (i % 2 == 1) ? 1 : 0);
            cycle();
        end
        set0(1'b0, 0, 0, 0);
        set1(1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();

        // Single requester latency
        set0(1'b1, 8'd1, 8'd2, 8'd4);
        cycle();
        set0(1'b0, 0, 0, 0);
        chk("single_out01", out01, 3);
        chk("single_busy", busy, 1);
        chk("single_early_val", resp0_val, 0);
        cycle();
        chk("single_resp0_val", resp0_val, 1);
        chk("single_resp1_val", resp1_val, 0);
        chk("single_resp_out", resp_out, 7);
        cycle();

        // Table vectors, one at a time, including wrap cases
        foreach (vecs[n]) begin
            if (vecs[n].id) set1(1'b1, vecs[n].a, vecs[n].b, vecs[n].c);
            else            set0(1'b1, vecs[n].a, vecs[n].b, vecs[n].c);
            got = 1'b0;
            for (int k = 0; k < 5 && !got; k++) begin
                #1;
                got = vecs[n].id ? req1_rdy : req0_rdy;
                cycle();
            end
            set0(1'b0, 0, 0, 0);
            set1(1'b0, 0, 0, 0);
            chk("vec_accept", got, 1);
            cycle();
            chk("vec_resp_val", vecs[n].id ? resp1_val : resp0_val, 1);
            chk("vec_resp_out", resp_out, vecs[n].exp);
            cycle();
        end

        // Backpressure: resp0 held off while req1 waits
        resp0_rdy = 1'b0;
        set0(1'b1, 8'd5, 8'd5, 8'd5);
        cycle();
        set0(1'b1, 8'd7, 8'd9, 8'd9);
        cycle();
        set0(1'b0, 0, 0, 0);
        set1(1'b1, 8'd1, 8'd1, 8'd1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_req1_rdy", req1_rdy, 0);
            chk("stall_resp0_val", resp0_val, 1);
            chk("stall_resp_out", resp_out, 8'h0F);
            chk("stall_out01", out01, 8'h10);
            cycle();
        end
        resp0_rdy = 1'b1;
        cycle();
        chk("stall_req1_taken", acc1, 1);
        set1(1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();

        // Asynchronous reset with two entries in flight
        set0(1'b1, 8'd3, 8'd3, 8'd3);
        cycle();
        set0(1'b0, 0, 0, 0);
        set1(1'b1, 8'd4, 8'd4, 8'd4);
        cycle();
        set1(1'b0, 0, 0, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_resp0_val", resp0_val, 0);
        chk("mrst_resp1_val", resp1_val, 0);
        chk("mrst_out01", out01, 0);
        chk("mrst_resp_out", resp_out, 0);
        q0.delete();
        q1.delete();
        set0(1'b1, 8'd1, 8'd1, 8'd1);
        set1(1'b1, 8'd2, 8'd2, 8'd2);
        reset_n = 1'b1;
        #1;
        chk("mrst_grant0", req0_rdy, 1);
        chk("mrst_grant1", req1_rdy, 0);
        cycle();
        set0(1'b0, 0, 0, 0);
        set1(1'b0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();

        // Random traffic; operands held while a request waits
        acc0 = 1'b0; acc1 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!(req0_val && !acc0))
                set0(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
            if (!(req1_val && !acc1))
                set1(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom));
            resp0_rdy = 1'($urandom_range(0, 1));
            resp1_rdy = 1'($urandom_range(0, 1));
            cycle();
        end

        // Drain and confirm nothing was lost
        set0(1'b0, 0, 0, 0);
        set1(1'b0, 0, 0, 0);
        resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (q0.size() == 0 && q1.size() == 0 && !busy) break;
            cycle();
        end
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);
        chk("drain_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
